// File: rtl/repairmb_partner_ctrl_if.sv
// Signal bundle between the REPAIRMB partner sequencer and its neighbours
// (MBINIT FSM, sideband codec, REPAIRMB checker).
interface repairmb_partner_ctrl_if #(
  parameter int unsigned MSG_W = 4
);
  logic             i_en;
  logic             i_sb_msg_valid;
  logic [MSG_W-1:0] i_sb_msg;
  logic             i_lane_result_valid;
  logic [1:0]       i_functional_lanes;
  logic             o_start_check;
  logic             o_second_check;
  logic [1:0]       o_functional_lanes;
  logic             i_done_check;
  logic             i_go_to_repeat;
  logic             i_go_to_train_error;
  logic             i_continue;
  logic             o_sb_msg_valid;
  logic [MSG_W-1:0] o_sb_msg;
  logic             o_done;
  logic             o_train_error;

  modport master (
    input  i_en, i_sb_msg_valid, i_sb_msg, i_lane_result_valid, i_functional_lanes,
           i_done_check, i_go_to_repeat, i_go_to_train_error, i_continue,
    output o_start_check, o_second_check, o_functional_lanes,
           o_sb_msg_valid, o_sb_msg, o_done, o_train_error
  );

  modport slave (
    output i_en, i_sb_msg_valid, i_sb_msg, i_lane_result_valid, i_functional_lanes,
           i_done_check, i_go_to_repeat, i_go_to_train_error, i_continue,
    input  o_start_check, o_second_check, o_functional_lanes,
           o_sb_msg_valid, o_sb_msg, o_done, o_train_error
  );
endinterface

// File: rtl/repairmb_partner_ctrl.sv
// Partner-side MBINIT.REPAIRMB sequencer: answers REPAIRMB sideband requests,
// drives the lane checker (first and optional post-degrade check) and picks the exit.
module repairmb_partner_ctrl #(
  parameter int unsigned    TIMEOUT_CYCLES   = 8000,
  parameter int unsigned    MSG_W            = 4,
  parameter logic [MSG_W-1:0] MSG_START_REQ    = MSG_W'(1),
  parameter logic [MSG_W-1:0] MSG_START_RESP   = MSG_W'(2),
  parameter logic [MSG_W-1:0] MSG_DEGRADE_REQ  = MSG_W'(3),
  parameter logic [MSG_W-1:0] MSG_DEGRADE_RESP = MSG_W'(4),
  parameter logic [MSG_W-1:0] MSG_END_REQ      = MSG_W'(5),
  parameter logic [MSG_W-1:0] MSG_END_RESP     = MSG_W'(6)
) (
  input logic                   CLK,
  input logic                   rst_n,
  repairmb_partner_ctrl_if.master bus
);

  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_START, S_WAIT_RESULT, S_CHECK,
    S_WAIT_DEGRADE, S_WAIT_END, S_DONE, S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [1:0]       lanes_q, lanes_d;
  logic             flag_q, flag_d;
  logic             start_check_q, start_check_d;
  logic             second_check_q, second_check_d;
  logic [1:0]       lanes_out_q, lanes_out_d;
  logic             tx_valid_q, tx_valid_d;
  logic [MSG_W-1:0] tx_msg_q, tx_msg_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic wd_expired, rx_start, rx_degrade, rx_end, counting;

  assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign rx_start   = bus.i_sb_msg_valid && (bus.i_sb_msg == MSG_START_REQ);
  assign rx_degrade = bus.i_sb_msg_valid && (bus.i_sb_msg == MSG_DEGRADE_REQ);
  assign rx_end     = bus.i_sb_msg_valid && (bus.i_sb_msg == MSG_END_REQ);
  assign counting   = state_q inside {S_WAIT_START, S_WAIT_RESULT, S_CHECK,
                                      S_WAIT_DEGRADE, S_WAIT_END};

  // State register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; watchdog expiry outranks any message or checker result
  always_comb begin
    state_d = state_q;
    if (!bus.i_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:         state_d = S_WAIT_START;
        S_WAIT_START:   if (wd_expired) state_d = S_ERROR;
                        else if (rx_start) state_d = S_WAIT_RESULT;
        S_WAIT_RESULT:  if (wd_expired) state_d = S_ERROR;
                        else if (bus.i_lane_result_valid) state_d = S_CHECK;
        S_CHECK: begin
          if (wd_expired) state_d = S_ERROR;
          else if (bus.i_done_check) begin
            if (bus.i_go_to_train_error)  state_d = S_ERROR;
            else if (bus.i_go_to_repeat)  state_d = flag_q ? S_ERROR : S_WAIT_DEGRADE;
            else if (bus.i_continue)      state_d = S_WAIT_END;
            else                          state_d = S_ERROR;
          end
        end
        S_WAIT_DEGRADE: if (wd_expired) state_d = S_ERROR;
                        else if (rx_degrade) state_d = S_WAIT_RESULT;
        S_WAIT_END:     if (wd_expired) state_d = S_ERROR;
                        else if (rx_end) state_d = S_DONE;
        S_DONE:         state_d = S_DONE;
        S_ERROR:        state_d = S_ERROR;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // Output / datapath next values, all derived from the transition being taken
  always_comb begin
    wd_d           = '0;
    lanes_d        = lanes_q;
    flag_d         = flag_q;
    tx_valid_d     = 1'b0;
    tx_msg_d       = '0;

    if (state_d == S_IDLE) begin
      lanes_d = 2'b00;
      flag_d  = 1'b0;
    end
    if (state_q == S_WAIT_RESULT && state_d == S_CHECK) lanes_d = bus.i_functional_lanes;
    if (state_q == S_WAIT_DEGRADE && state_d == S_WAIT_RESULT) flag_d = 1'b1;
    if (counting && state_d == state_q) wd_d = wd_q + WD_W'(1);

    if (state_q == S_WAIT_START && state_d == S_WAIT_RESULT) begin
      tx_valid_d = 1'b1;
      tx_msg_d   = MSG_START_RESP;
    end else if (state_q == S_WAIT_DEGRADE && state_d == S_WAIT_RESULT) begin
      tx_valid_d = 1'b1;
      tx_msg_d   = MSG_DEGRADE_RESP;
    end else if (state_q == S_WAIT_END && state_d == S_DONE) begin
      tx_valid_d = 1'b1;
      tx_msg_d   = MSG_END_RESP;
    end

    start_check_d  = (state_d == S_CHECK);
    second_check_d = (state_d == S_CHECK) && flag_d;
    lanes_out_d    = (state_d == S_CHECK) ? lanes_d : 2'b00;
    done_d         = (state_d == S_DONE);
    err_d          = (state_d == S_ERROR);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wd_q           <= '0;
      lanes_q        <= 2'b00;
      flag_q         <= 1'b0;
      start_check_q  <= 1'b0;
      second_check_q <= 1'b0;
      lanes_out_q    <= 2'b00;
      tx_valid_q     <= 1'b0;
      tx_msg_q       <= '0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      wd_q           <= wd_d;
      lanes_q        <= lanes_d;
      flag_q         <= flag_d;
      start_check_q  <= start_check_d;
      second_check_q <= second_check_d;
      lanes_out_q    <= lanes_out_d;
      tx_valid_q     <= tx_valid_d;
      tx_msg_q       <= tx_msg_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign bus.o_start_check      = start_check_q;
  assign bus.o_second_check     = second_check_q;
  assign bus.o_functional_lanes = lanes_out_q;
  assign bus.o_sb_msg_valid     = tx_valid_q;
  assign bus.o_sb_msg           = tx_msg_q;
  assign bus.o_done             = done_q;
  assign bus.o_train_error      = err_q;

endmodule

// File: tb/tb_repairmb_partner_ctrl.sv
// Bench for repairmb_partner_ctrl: drives REPAIRMB sessions with randomized lane maps
// and delays, using a registered checker stub and an outcome model from the REPAIRMB rules.
module tb_repairmb_partner_ctrl;

  localparam logic [3:0] START_REQ    = 4'd1;
  localparam logic [3:0] START_RESP   = 4'd2;
  localparam logic [3:0] DEGRADE_REQ  = 4'd3;
  localparam logic [3:0] DEGRADE_RESP = 4'd4;
  localparam logic [3:0] END_REQ      = 4'd5;
  localparam logic [3:0] END_RESP     = 4'd6;

  logic CLK = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   force_repeat = 1'b0;
  logic [1:0] first_map;

  repairmb_partner_ctrl_if #(.MSG_W(4)) bus ();

  repairmb_partner_ctrl #(.TIMEOUT_CYCLES(64), .MSG_W(4)) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Registered checker stand-in: answers one cycle after o_start_check rises
  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      bus.i_done_check        <= 1'b0;
      bus.i_go_to_repeat      <= 1'b0;
      bus.i_go_to_train_error <= 1'b0;
      bus.i_continue          <= 1'b0;
      first_map               <= 2'b00;
    end else begin
      bus.i_done_check        <= bus.o_start_check && !bus.i_done_check;
      bus.i_go_to_repeat      <= 1'b0;
      bus.i_go_to_train_error <= 1'b0;
      bus.i_continue          <= 1'b0;
      if (bus.o_start_check && !bus.i_done_check) begin
        if (!bus.o_second_check) begin
          first_map <= bus.o_functional_lanes;
          case (bus.o_functional_lanes)
            2'b11:   bus.i_continue          <= 1'b1;
            2'b00:   bus.i_go_to_train_error <= 1'b1;
            default: bus.i_go_to_repeat      <= 1'b1;
          endcase
        end else if (force_repeat) bus.i_go_to_repeat <= 1'b1;
        else if (bus.o_functional_lanes == first_map) bus.i_continue <= 1'b1;
        else bus.i_go_to_train_error <= 1'b1;
      end
    end
  end

  // Session outcome from the REPAIRMB rules: 1 = done, 0 = train error
  function automatic bit model_outcome(input logic [1:0] f, input logic [1:0] s,
                                       input bit frep, output bit degrade);
    degrade = (f == 2'b01) || (f == 2'b10);
    if (f == 2'b11) return 1'b1;
    if (f == 2'b00) return 1'b0;
    if (frep) return 1'b0;
    return (s == f);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_msg(input logic [3:0] code, output logic v, output logic [3:0] m);
    bus.i_sb_msg_valid = 1'b1;
    bus.i_sb_msg       = code;
    @(negedge CLK);
    v = bus.o_sb_msg_valid;
    m = bus.o_sb_msg;
    bus.i_sb_msg_valid = 1'b0;
    bus.i_sb_msg       = 4'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_en = 1'b1;
    bus.i_sb_msg_valid = 1'b0;
    bus.i_sb_msg = 4'd0;
    bus.i_lane_result_valid = 1'b0;
    bus.i_functional_lanes = 2'b00;
    idle(3);
    n_tests++;
    if ({bus.o_start_check, bus.o_second_check, bus.o_functional_lanes, bus.o_sb_msg_valid,
         bus.o_sb_msg, bus.o_done, bus.o_train_error} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=0", {bus.o_start_check, bus.o_second_check,
               bus.o_functional_lanes, bus.o_sb_msg_valid, bus.o_sb_msg, bus.o_done, bus.o_train_error});
    end
    bus.i_en = 1'b0;
    @(negedge CLK);
    rst_n = 1'b1;
    idle(2);
    n_tests++;
    if (bus.o_train_error !== 1'b0 || bus.o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_hold done=%b err=%b exp=0/0", bus.o_done, bus.o_train_error);
    end
  endtask

  // One full REPAIRMB session; abort_pass >= 0 drops i_en in that check's first cycle
  task automatic test_session(input string name, input logic [1:0] f, input logic [1:0] s,
                              input bit frep, input int abort_pass);
    logic v; logic [3:0] m; logic [1:0] map;
    bit degr, exp_done, saw_done;
    int cnt, npass;
    exp_done = model_outcome(f, s, frep, degr);
    npass = degr ? 2 : 1;
    force_repeat = frep;
    bus.i_en = 1'b1;
    @(negedge CLK);

    bus.i_sb_msg_valid = 1'b1;
    bus.i_sb_msg = END_REQ;
    @(negedge CLK);
    bus.i_sb_msg_valid = 1'b0;
    n_tests++;
    if (bus.o_sb_msg_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s stray_msg_tx got=%b exp=0", name, bus.o_sb_msg_valid);
    end
    idle($urandom_range(0, 3));

    send_msg(START_REQ, v, m);
    n_tests++;
    if (v !== 1'b1 || m !== START_RESP) begin
      n_fail++;
      $display("FAIL %s start_resp got=%b/%0d exp=1/%0d", name, v, m, START_RESP);
    end
    @(negedge CLK);
    n_tests++;
    if (bus.o_sb_msg_valid !== 1'b0 || bus.o_sb_msg !== 4'd0) begin
      n_fail++;
      $display("FAIL %s tx_pulse_width got=%b/%0d exp=0/0", name, bus.o_sb_msg_valid, bus.o_sb_msg);
    end

    for (int pass = 0; pass < npass; pass++) begin
      map = (pass == 0) ? f : s;
      idle($urandom_range(0, 4));
      bus.i_lane_result_valid = 1'b1;
      bus.i_functional_lanes  = map;
      @(negedge CLK);
      bus.i_lane_result_valid = 1'b0;
      bus.i_functional_lanes  = 2'($urandom);
      n_tests++;
      if (bus.o_start_check !== 1'b1 || bus.o_functional_lanes !== map ||
          bus.o_second_check !== 1'(pass)) begin
        n_fail++;
        $display("FAIL %s check%0d_drive start=%b lanes=%b second=%b exp=1/%b/%0d", name, pass,
                 bus.o_start_check, bus.o_functional_lanes, bus.o_second_check, map, pass);
      end
      if (pass == abort_pass) begin
        bus.i_en = 1'b0;
        @(negedge CLK);
        n_tests++;
        if ({bus.o_start_check, bus.o_second_check, bus.o_functional_lanes, bus.o_sb_msg_valid,
             bus.o_done, bus.o_train_error} !== 7'd0) begin
          n_fail++;
          $display("FAIL %s abort_clear got=%b exp=0", name, {bus.o_start_check, bus.o_second_check,
                   bus.o_functional_lanes, bus.o_sb_msg_valid, bus.o_done, bus.o_train_error});
        end
        force_repeat = 1'b0;
        return;
      end
      cnt = 0;
      saw_done = 1'b0;
      while (bus.o_start_check === 1'b1 && cnt < 8) begin
        cnt++;
        saw_done |= bus.i_done_check;
        @(negedge CLK);
      end
      n_tests++;
      if (cnt != 2 || !saw_done) begin
        n_fail++;
        $display("FAIL %s check%0d_start_width got=%0d done_seen=%b exp=2/1", name, pass, cnt, saw_done);
      end
      if (pass == 0 && degr) begin
        n_tests++;
        if (bus.o_train_error !== 1'b0) begin
          n_fail++;
          $display("FAIL %s repeat_no_err got=%b exp=0", name, bus.o_train_error);
        end
        idle($urandom_range(0, 3));
        send_msg(DEGRADE_REQ, v, m);
        n_tests++;
        if (v !== 1'b1 || m !== DEGRADE_RESP) begin
          n_fail++;
          $display("FAIL %s degrade_resp got=%b/%0d exp=1/%0d", name, v, m, DEGRADE_RESP);
        end
      end
    end

    if (exp_done) begin
      n_tests++;
      if (bus.o_train_error !== 1'b0 || bus.o_done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s wait_end_state done=%b err=%b exp=0/0", name, bus.o_done, bus.o_train_error);
      end
      idle($urandom_range(0, 3));
      send_msg(END_REQ, v, m);
      n_tests++;
      if (v !== 1'b1 || m !== END_RESP || bus.o_done !== 1'b1) begin
        n_fail++;
        $display("FAIL %s end_resp got=%b/%0d done=%b exp=1/%0d/1", name, v, m, bus.o_done, END_RESP);
      end
    end else begin
      n_tests++;
      if (bus.o_train_error !== 1'b1 || bus.o_done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s train_error got err=%b done=%b exp=1/0", name, bus.o_train_error, bus.o_done);
      end
    end
    idle(3);
    n_tests++;
    if (bus.o_done !== exp_done || bus.o_train_error !== !exp_done) begin
      n_fail++;
      $display("FAIL %s exit_held done=%b err=%b exp=%b/%b", name, bus.o_done, bus.o_train_error,
               exp_done, !exp_done);
    end
    bus.i_en = 1'b0;
    @(negedge CLK);
    n_tests++;
    if (bus.o_done !== 1'b0 || bus.o_train_error !== 1'b0) begin
      n_fail++;
      $display("FAIL %s disable_clear done=%b err=%b exp=0/0", name, bus.o_done, bus.o_train_error);
    end
    force_repeat = 1'b0;
  endtask

  task automatic test_timeout();
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    bus.i_en = 1'b1;
    while (!seen && k < 200) begin
      @(negedge CLK);
      k++;
      if (k == 30) begin
        bus.i_sb_msg_valid = 1'b1;
        bus.i_sb_msg = END_REQ;
      end else begin
        bus.i_sb_msg_valid = 1'b0;
      end
      if (bus.o_train_error === 1'b1) seen = 1'b1;
    end
    bus.i_sb_msg_valid = 1'b0;
    // Entered WAIT_START on the first edge, so expiry is 64 edges later
    n_tests++;
    if (k != 65 || !seen) begin
      n_fail++;
      $display("FAIL timeout_latency got=%0d seen=%b exp=65/1", k, seen);
    end
    n_tests++;
    if (bus.o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_done got=%b exp=0", bus.o_done);
    end
    bus.i_en = 1'b0;
    @(negedge CLK);
    n_tests++;
    if (bus.o_train_error !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear got=%b exp=0", bus.o_train_error);
    end
  endtask

  task automatic test_random();
    logic [1:0] f, s;
    for (int i = 0; i < 8; i++) begin
      f = 2'($urandom);
      s = ($urandom_range(0, 1) == 0) ? f : 2'($urandom);
      test_session("random", f, s, 1'b0, -1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit reached exp=finish");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_session("happy", 2'b11, 2'b11, 1'b0, -1);
    test_session("degrade", 2'b01, 2'b01, 1'b0, -1);
    test_session("degrade_mismatch", 2'b10, 2'b01, 1'b0, -1);
    test_session("lanes_zero", 2'b00, 2'b00, 1'b0, -1);
    test_session("repeat_twice", 2'b10, 2'b10, 1'b1, -1);
    test_timeout();
    test_session("abort_first", 2'b11, 2'b11, 1'b0, 0);
    test_session("abort_second", 2'b01, 2'b01, 1'b0, 1);
    test_session("back_to_back", 2'b11, 2'b11, 1'b0, -1);
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
